ats21_issuer: RTL and testbench

ATS21_ISSUER -- requirements
Module: ats21_issuer

---
 rtl/ats21_pkg.sv | 29 ++
 rtl/ats21_instr_fifo.sv | 57 +++++
 rtl/ats21_issuer.sv | 197 +++++++++++++++++++
 tb/tb_ats21_issuer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// ats21_pkg -- shared types and widths for the ATS21 instruction issuer.
//   Opcode encoding of instruction bits [31:29], issuer FSM state type,
//   and the half-word / instruction / response data widths.
package ats21_pkg;

    localparam int HALF_W  = 16;
    localparam int INSTR_W = 32;
    localparam int DATA_W  = 24;
    localparam int STAT_W  = 2;
    localparam int SRC_W   = 2;

    typedef enum logic [2:0] {
        OP_NOP           = 3'b000,
        OP_SET_CLOCK     = 3'b001,
        OP_TOGGLE_BC     = 3'b010,
        OP_SET_MODE      = 3'b011,
        OP_SET_ALARM     = 3'b101,
        OP_SET_COUNTDOWN = 3'b110,
        OP_TOGGLE_AT     = 3'b111
    } ats21_opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_WAIT = 2'd3
    } ats21_state_e;

endpackage

// File: rtl/ats21_instr_fifo.sv
// ats21_instr_fifo -- per-client instruction FIFO.
//   clk, reset (async active-low) ; push/din write side, pop/dout read side
//   (dout shows the head entry) ; full/empty status.
//   DEPTH must be a power of two so the pointers wrap for free.
module ats21_instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_cnt == FULL_CNT);
    assign empty  = (r_cnt == '0);
    assign dout   = r_mem[r_rd];
    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/ats21_issuer.sv
// ats21_issuer -- pairs instructions from two clients (A, B) and issues them
//   to an ATS21 device as a high half-word strobe cycle followed by a low
//   half-word cycle, then waits for the device response.
// Ports:
//   clk, reset (async active-low)
//   a_valid/a_instr/a_ready, b_valid/b_instr/b_ready : client push interfaces
//   dut_req, dut_ctrlA, dut_ctrlB                    : device request side
//   dut_ready, dut_stat, dut_data                    : device response side
//   rsp_valid, rsp_stat, rsp_data, rsp_src, rsp_timeout : client response
//   busy : transaction in flight
// Build option: define ATS21_ISSUER_TIMEOUT_EN to end a WAIT that lasts
//   TIMEOUT_CYCLES cycles with a timeout response.
module ats21_issuer
    import ats21_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_valid,
    input  logic [INSTR_W-1:0] a_instr,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [INSTR_W-1:0] b_instr,
    output logic               b_ready,
    output logic               dut_req,
    output logic [HALF_W-1:0]  dut_ctrlA,
    output logic [HALF_W-1:0]  dut_ctrlB,
    input  logic               dut_ready,
    input  logic [STAT_W-1:0]  dut_stat,
    input  logic [DATA_W-1:0]  dut_data,
    output logic               rsp_valid,
    output logic [STAT_W-1:0]  rsp_stat,
    output logic [DATA_W-1:0]  rsp_data,
    output logic [SRC_W-1:0]   rsp_src,
    output logic               rsp_timeout,
    output logic               busy
);

    ats21_state_e       r_state;
    logic               r_en;
    logic [INSTR_W-1:0] r_cur_a;
    logic [INSTR_W-1:0] r_cur_b;
    logic [SRC_W-1:0]   r_src;
    logic               r_req;
    logic [HALF_W-1:0]  r_ctrl_a;
    logic [HALF_W-1:0]  r_ctrl_b;
    logic               r_busy;
    logic               r_rsp_valid;
    logic [STAT_W-1:0]  r_rsp_stat;
    logic [DATA_W-1:0]  r_rsp_data;
    logic [SRC_W-1:0]   r_rsp_src;

    logic               w_a_full, w_a_empty, w_a_pop;
    logic               w_b_full, w_b_empty, w_b_pop;
    logic [INSTR_W-1:0] w_a_head, w_b_head;
    logic [INSTR_W-1:0] w_sel_a, w_sel_b;

    // The high halves of cur_a/cur_b go straight to the ctrl registers at
    // the IDLE decision, so the stored copies are only read for the low half.
    logic w_cur_hi_unused;
    assign w_cur_hi_unused = ^{r_cur_a[INSTR_W-1:HALF_W], r_cur_b[INSTR_W-1:HALF_W],
                               TIMEOUT_CYCLES[0]};

    // r_en keeps both readies low during reset and for no longer.
    assign a_ready = r_en && !w_a_full;
    assign b_ready = r_en && !w_b_full;

    assign w_a_pop = (r_state == ST_IDLE) && !w_a_empty;
    assign w_b_pop = (r_state == ST_IDLE) && !w_b_empty;
    // An empty client contributes a NOP to the paired transaction.
    assign w_sel_a = w_a_empty ? '0 : w_a_head;
    assign w_sel_b = w_b_empty ? '0 : w_b_head;

    ats21_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo_a (
        .clk   (clk),
        .reset (reset),
        .push  (a_valid && a_ready),
        .din   (a_instr),
        .pop   (w_a_pop),
        .dout  (w_a_head),
        .full  (w_a_full),
        .empty (w_a_empty)
    );

    ats21_instr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W)) u_fifo_b (
        .clk   (clk),
        .reset (reset),
        .push  (b_valid && b_ready),
        .din   (b_instr),
        .pop   (w_b_pop),
        .dout  (w_b_head),
        .full  (w_b_full),
        .empty (w_b_empty)
    );

`ifdef ATS21_ISSUER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_timeout;
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_en        <= 1'b0;
            r_cur_a     <= '0;
            r_cur_b     <= '0;
            r_src       <= '0;
            r_req       <= 1'b0;
            r_ctrl_a    <= '0;
            r_ctrl_b    <= '0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_stat  <= '0;
            r_rsp_data  <= '0;
            r_rsp_src   <= '0;
`ifdef ATS21_ISSUER_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            r_en        <= 1'b1;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_a_empty || !w_b_empty) begin
                        r_cur_a  <= w_sel_a;
                        r_cur_b  <= w_sel_b;
                        r_src    <= {!w_b_empty, !w_a_empty};
                        r_req    <= 1'b1;
                        r_ctrl_a <= w_sel_a[INSTR_W-1:HALF_W];
                        r_ctrl_b <= w_sel_b[INSTR_W-1:HALF_W];
                        r_busy   <= 1'b1;
                        r_state  <= ST_HI;
                    end
                end
                ST_HI: begin
                    r_req    <= 1'b0;
                    r_ctrl_a <= r_cur_a[HALF_W-1:0];
                    r_ctrl_b <= r_cur_b[HALF_W-1:0];
                    r_state  <= ST_LO;
                end
                ST_LO: begin
                    r_ctrl_a <= '0;
                    r_ctrl_b <= '0;
`ifdef ATS21_ISSUER_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dut_ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_stat  <= dut_stat;
                        r_rsp_data  <= dut_data;
                        r_rsp_src   <= r_src;
`ifdef ATS21_ISSUER_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
`ifdef ATS21_ISSUER_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_stat    <= '0;
                        r_rsp_data    <= '0;
                        r_rsp_src     <= r_src;
                        r_rsp_timeout <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dut_req   = r_req;
    assign dut_ctrlA = r_ctrl_a;
    assign dut_ctrlB = r_ctrl_b;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_stat  = r_rsp_stat;
    assign rsp_data  = r_rsp_data;
    assign rsp_src   = r_rsp_src;

endmodule

// File: tb/tb_ats21_issuer.sv
// tb_ats21_issuer -- randomized and directed stimulus for ats21_issuer,
//   checked every cycle against a transaction-level reference model built
//   from per-client instruction queues and a cycles-since-issue count.
// Build option: ATS21_ISSUER_TIMEOUT_EN selects the timeout expectations.
module tb_ats21_issuer;

    localparam int DEPTH = 2;
    localparam int TMO   = 64;

    logic        clk;
    logic        reset;
    logic        a_valid, b_valid;
    logic [31:0] a_instr, b_instr;
    logic        a_ready, b_ready;
    logic        dut_req;
    logic [15:0] dut_ctrlA, dut_ctrlB;
    logic        dut_ready;
    logic [1:0]  dut_stat;
    logic [23:0] dut_data;
    logic        rsp_valid;
    logic [1:0]  rsp_stat;
    logic [23:0] rsp_data;
    logic [1:0]  rsp_src;
    logic        rsp_timeout;
    logic        busy;

    ats21_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready),
        .b_valid(b_valid), .b_instr(b_instr), .b_ready(b_ready),
        .dut_req(dut_req), .dut_ctrlA(dut_ctrlA), .dut_ctrlB(dut_ctrlB),
        .dut_ready(dut_ready), .dut_stat(dut_stat), .dut_data(dut_data),
        .rsp_valid(rsp_valid), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc_a = 0;
    int n_tmo_seen = 0;

    // Reference model: queued instructions per client, current pair, and
    // m_k = cycles since the request strobe (-1 when nothing is in flight).
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] m_cur_a, m_cur_b;
    int          m_k;
    logic        m_en;
    logic        m_pulse;
    logic [1:0]  m_stat, m_src, m_pend_src;
    logic [23:0] m_data;
    logic        m_tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_cur_a = '0; m_cur_b = '0; m_k = -1; m_en = 1'b0; m_pulse = 1'b0;
        m_stat = '0; m_src = '0; m_pend_src = '0; m_data = '0; m_tmo = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented.
    task automatic model_step();
        bit pa, pb;
        pa = a_valid && m_en && (qa.size() < DEPTH);
        pb = b_valid && m_en && (qb.size() < DEPTH);
        m_pulse = 1'b0;
        if (m_k < 0) begin
            if (qa.size() > 0 || qb.size() > 0) begin
                m_pend_src = {qb.size() > 0, qa.size() > 0};
                m_cur_a = '0;
                m_cur_b = '0;
                if (qa.size() > 0) m_cur_a = qa.pop_front();
                if (qb.size() > 0) m_cur_b = qb.pop_front();
                m_k = 0;
            end
        end else if (m_k < 2) begin
            m_k++;
        end else if (dut_ready) begin
            m_pulse = 1'b1; m_stat = dut_stat; m_data = dut_data;
            m_src = m_pend_src; m_tmo = 1'b0; m_k = -1;
        end
`ifdef ATS21_ISSUER_TIMEOUT_EN
        else if (m_k - 2 == TMO - 1) begin
            m_pulse = 1'b1; m_stat = '0; m_data = '0;
            m_src = m_pend_src; m_tmo = 1'b1; m_k = -1;
        end
`endif
        else begin
            m_k++;
        end
        if (pa) qa.push_back(a_instr);
        if (pb) qb.push_back(b_instr);
        m_en = 1'b1;
    endtask

    task automatic check_outputs();
        logic [15:0] ea, eb;
        ea = (m_k == 0) ? m_cur_a[31:16] : (m_k == 1) ? m_cur_a[15:0] : 16'h0;
        eb = (m_k == 0) ? m_cur_b[31:16] : (m_k == 1) ? m_cur_b[15:0] : 16'h0;
        chk("dut_req",     dut_req,     m_k == 0);
        chk("dut_ctrlA",   dut_ctrlA,   ea);
        chk("dut_ctrlB",   dut_ctrlB,   eb);
        chk("busy",        busy,        m_k >= 0);
        chk("rsp_valid",   rsp_valid,   m_pulse);
        chk("rsp_stat",    rsp_stat,    m_stat);
        chk("rsp_data",    rsp_data,    m_data);
        chk("rsp_src",     rsp_src,     m_src);
        chk("rsp_timeout", rsp_timeout, m_tmo);
        chk("a_ready",     a_ready,     m_en && (qa.size() < DEPTH));
        chk("b_ready",     b_ready,     m_en && (qb.size() < DEPTH));
    endtask

    // One clock: check, drive this cycle's inputs, then step the model at the edge.
    task automatic cycle(input logic av, input logic [31:0] ai,
                         input logic bv, input logic [31:0] bi,
                         input logic dr, input logic [1:0] ds, input logic [23:0] dd);
        @(negedge clk);
        check_outputs();
        if (rsp_valid && rsp_timeout) n_tmo_seen++;
        a_valid = av; a_instr = ai; b_valid = bv; b_instr = bi;
        dut_ready = dr; dut_stat = ds; dut_data = dd;
        if (a_valid && a_ready) n_acc_a++;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n, input logic dr);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, dr, 2'b10, 24'h0000AA);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; dut_ready = 1'b0;
        a_instr = '0; b_instr = '0; dut_stat = '0; dut_data = '0;
        reset = 1'b0;
        #1;
        chk("rst_req",    dut_req,   1'b0);
        chk("rst_ctrlA",  dut_ctrlA, 16'h0);
        chk("rst_ctrlB",  dut_ctrlB, 16'h0);
        chk("rst_busy",   busy,      1'b0);
        chk("rst_rspv",   rsp_valid, 1'b0);
        chk("rst_a_rdy",  a_ready,   1'b0);
        chk("rst_b_rdy",  b_ready,   1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; dut_ready = 1'b0;
        a_instr = '0; b_instr = '0; dut_stat = '0; dut_data = '0;
        model_reset();
        do_reset();

        // Single A instruction; dut_ready pulses outside WAIT are ignored.
        cycle(1'b1, 32'h2200_0000, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11, 24'hFFFFFF);
        #1;
        chk("hi_req",    dut_req,   1'b1);
        chk("hi_ctrlA",  dut_ctrlA, 16'h2200);
        chk("hi_ctrlB",  dut_ctrlB, 16'h0000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11, 24'hFFFFFF);
        #1;
        chk("lo_req",    dut_req,   1'b0);
        chk("lo_ctrlA",  dut_ctrlA, 16'h0000);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b11, 24'hFFFFFF);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b01, 24'h000025);
        #1;
        chk("rsp_v1",    rsp_valid, 1'b1);
        chk("rsp_stat1", rsp_stat,  2'b01);
        chk("rsp_data1", rsp_data,  24'h000025);
        chk("rsp_src1",  rsp_src,   2'b01);
        chk("idle_busy", busy,      1'b0);
        idle(3, 1'b0);

        // Paired A/B push.
        cycle(1'b1, 32'h2000_0000, 1'b1, 32'h2240_0000, 1'b0, 2'b00, 24'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        #1;
        chk("pair_ctrlA", dut_ctrlA, 16'h2000);
        chk("pair_ctrlB", dut_ctrlB, 16'h2240);
        idle(3, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b10, 24'h123456);
        #1;
        chk("pair_src", rsp_src, 2'b11);
        idle(3, 1'b0);

        // Backpressure: only three accepted while the device stays silent.
        n_acc_a = 0;
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        chk("acc3", n_acc_a, 3);
        #1;
        chk("full_rdy", a_ready, 1'b0);
        for (int i = 0; i < 10 && n_acc_a < 4; i++)
            cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1, 2'b01, 24'h000111);
        chk("acc4", n_acc_a, 4);
        idle(30, 1'b1);

        // Device never answers.
        n_tmo_seen = 0;
        cycle(1'b1, 32'hA000_0001, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        idle(80, 1'b0);
`ifdef ATS21_ISSUER_TIMEOUT_EN
        chk("tmo_seen", n_tmo_seen, 1);
        chk("tmo_data", rsp_data, 24'h0);
`else
        chk("tmo_busy", busy, 1'b1);
`endif
        do_reset();

        // Reset while the low half is on the bus.
        cycle(1'b1, 32'h6000_1234, 1'b1, 32'hE000_0042, 1'b0, 2'b00, 24'h0);
        cycle(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 24'h0);
        #1;
        chk("lo2_ctrlA", dut_ctrlA, 16'h1234);
        do_reset();
        idle(4, 1'b1);
        #1;
        chk("post_rst_rspv", rsp_valid, 1'b0);
        chk("post_rst_rdy",  a_ready,   1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 499) do_reset();
            cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
                  ($urandom_range(0, 3) == 0), 2'($urandom), 24'($urandom));
        end
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
